// File: rtl/arb4_encode_ctrl.sv
// Four-way round-robin arbiter with an encoded grant index, done/req-drop release
// and a forced release after HOLD_MAX cycles of continuous ownership.
module arb4_encode_ctrl #(
   parameter int unsigned HOLD_MAX = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [7:0] HCNT_LAST = 8'(HOLD_MAX - 1);

   state_t     state;
   logic [1:0] last;
   logic [7:0] hcnt;
   logic [1:0] cand;
   logic [1:0] win_idx;
   logic       win_found;
   logic       owner_req;
   logic       expire;

   // Index i lives on req[3-i], which for a 2-bit index is simply req[~i].
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      win_idx   = last;
      win_found = 1'b0;
      cand      = last;
      for (int k = 1; k <= 4; k++) begin
         cand = last + 2'(k);
         if (!win_found && req[~cand]) begin
            win_idx   = cand;
            win_found = 1'b1;
         end
      end
   end

   assign owner_req = req[~gnt_idx];
   assign expire    = (hcnt == HCNT_LAST);

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         gnt       <= 4'b0000;
         gnt_idx   <= 2'b00;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
         hcnt      <= 8'd0;
         last      <= 2'd3;
      end else begin
         case (state)
            IDLE: begin
               timeout <= 1'b0;
               if (win_found) begin
                  state     <= GRANT;
                  gnt       <= 4'b1000 >> win_idx;
                  gnt_idx   <= win_idx;
                  gnt_valid <= 1'b1;
                  hcnt      <= 8'd0;
                  last      <= win_idx;
               end
            end
            GRANT: begin
               if (done || !owner_req || expire) begin
                  state     <= IDLE;
                  gnt       <= 4'b0000;
                  gnt_idx   <= 2'b00;
                  gnt_valid <= 1'b0;
                  // Only a pure expiry counts as forced; done or a dropped request wins.
                  timeout   <= !done && owner_req;
               end else begin
                  hcnt <= hcnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_arb4_encode_ctrl.sv
// Self-checking bench for arb4_encode_ctrl: directed scenarios plus a long
// randomized run against a cycle-level behavioural model of the arbitration rules.
module tb_arb4_encode_ctrl;

   localparam int HOLD = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout;
   logic [7:0] obs;

   int vectors = 0;
   int errors  = 0;

   // Behavioural model state
   bit m_busy, m_to;
   int m_owner, m_hold, m_last;

   arb4_encode_ctrl #(.HOLD_MAX(HOLD)) dut (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
   );

   always #5 clk = ~clk;

   assign obs = {gnt, gnt_idx, gnt_valid, timeout};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [7:0] exp_out();
      logic [3:0] g;
      logic [1:0] ix;
      g  = m_busy ? 4'(1 << (3 - m_owner)) : 4'b0000;
      ix = m_busy ? 2'(m_owner) : 2'b00;
      return {g, ix, m_busy, m_to};
   endfunction

   task automatic model_reset();
      m_busy = 0; m_to = 0; m_owner = 0; m_hold = 0; m_last = 3;
   endtask

   // One rising edge of the arbitration rules, using the inputs sampled at that edge.
   task automatic model_step(input logic [3:0] r, input logic d);
      if (!m_busy) begin
         m_to = 0;
         for (int k = 1; k <= 4; k++) begin
            int i;
            i = (m_last + k) % 4;
            if (!m_busy && r[3 - i]) begin
               m_busy = 1; m_owner = i; m_hold = 0; m_last = i;
            end
         end
      end else if (d || !r[3 - m_owner]) begin
         m_busy = 0; m_to = 0;
      end else if (m_hold == HOLD - 1) begin
         m_busy = 0; m_to = 1;
      end else begin
         m_hold++;
      end
   endtask

   task automatic step(input logic [3:0] r, input logic d);
      req  = r;
      done = d;
      @(posedge clk);
      model_step(r, d);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 4'b0000; done = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (obs !== 8'h00) begin
         errors++;
         $display("FAIL reset_state: got %b required %b", obs, 8'h00);
      end
      step(4'b0000, 1'b0);
      vectors++;
      if (obs !== 8'h00) begin
         errors++;
         $display("FAIL idle_no_req: got %b required %b", obs, 8'h00);
      end
   endtask

   task automatic test_single();
      do_reset();
      step(4'b0001, 1'b0);
      vectors++;
      if (obs !== {4'b0001, 2'b11, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL single_grant: got %b required %b", obs, {4'b0001, 2'b11, 1'b1, 1'b0});
      end
      step(4'b0000, 1'b0);
      vectors++;
      if (obs !== 8'h00) begin
         errors++;
         $display("FAIL single_req_drop: got %b required %b", obs, 8'h00);
      end
   endtask

   task automatic test_round_robin();
      int order [5] = '{0, 1, 2, 3, 0};
      logic [7:0] want;
      do_reset();
      for (int n = 0; n < 5; n++) begin
         step(4'b1111, 1'b0);
         want = {4'(4'b1000 >> order[n]), 2'(order[n]), 1'b1, 1'b0};
         vectors++;
         if (obs !== want) begin
            errors++;
            $display("FAIL rr_grant_%0d: got %b required %b", n, obs, want);
         end
         step(4'b1111, 1'b1);
         vectors++;
         if (obs !== 8'h00) begin
            errors++;
            $display("FAIL rr_idle_gap_%0d: got %b required %b", n, obs, 8'h00);
         end
      end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int n = 0; n < HOLD; n++) begin
         step(4'b0100, 1'b0);
         vectors++;
         if (obs !== {4'b0100, 2'b01, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL hold_cycle_%0d: got %b required %b", n, obs, {4'b0100, 2'b01, 1'b1, 1'b0});
         end
      end
      step(4'b0100, 1'b0);
      vectors++;
      if (obs !== 8'b0000_00_0_1) begin
         errors++;
         $display("FAIL timeout_pulse: got %b required %b", obs, 8'b0000_00_0_1);
      end
      step(4'b0100, 1'b0);
      vectors++;
      if (obs !== {4'b0100, 2'b01, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL regrant_after_timeout: got %b required %b", obs, {4'b0100, 2'b01, 1'b1, 1'b0});
      end
   endtask

   task automatic test_done_expiry();
      do_reset();
      repeat (HOLD) step(4'b0100, 1'b0);
      step(4'b0100, 1'b1);
      vectors++;
      if (obs !== 8'h00) begin
         errors++;
         $display("FAIL done_beats_expiry: got %b required %b", obs, 8'h00);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      step(4'b1110, 1'b0);
      step(4'b1110, 1'b0);
      rst = 1'b1;
      #2;
      vectors++;
      if ({gnt, gnt_idx, gnt_valid} !== 7'd0) begin
         errors++;
         $display("FAIL async_reset_drop: got %b required %b", {gnt, gnt_idx, gnt_valid}, 7'd0);
      end
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      step(4'b1111, 1'b0);
      vectors++;
      if (obs !== {4'b1000, 2'b00, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL post_reset_first_grant: got %b required %b", obs, {4'b1000, 2'b00, 1'b1, 1'b0});
      end
   endtask

   task automatic test_random();
      logic [3:0] r;
      logic       d;
      logic       prev_valid;
      int         waits [4];
      int         worst;
      do_reset();
      r = 4'b0000;
      prev_valid = 1'b0;
      for (int j = 0; j < 4; j++) waits[j] = 0;
      for (int n = 0; n < 10000; n++) begin
         r = r ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
         d = ($urandom_range(0, 5) == 0);
         step(r, d);
         vectors++;
         if (obs !== exp_out()) begin
            errors++;
            $display("FAIL random_model cycle %0d: got %b required %b", n, obs, exp_out());
         end
         vectors++;
         if (!$onehot0(gnt) || (gnt_valid !== (gnt != 4'b0000)) ||
             (gnt_valid && (gnt !== (4'b1000 >> gnt_idx)))) begin
            errors++;
            $display("FAIL random_encoding cycle %0d: got gnt=%b idx=%0d valid=%b required one-hot consistent",
                     n, gnt, gnt_idx, gnt_valid);
         end
         if (gnt_valid && !prev_valid) begin
            worst = 0;
            for (int j = 0; j < 4; j++) begin
               if (j == int'(gnt_idx)) waits[j] = 0;
               else if (r[3 - j])      waits[j]++;
               else                    waits[j] = 0;
               if (waits[j] > worst) worst = waits[j];
            end
            vectors++;
            if (worst > 4) begin
               errors++;
               $display("FAIL starvation cycle %0d: got %0d grants to others required at most 4", n, worst);
            end
         end
         prev_valid = gnt_valid;
      end
   endtask

   initial begin
      rst = 1'b1; req = 4'b0000; done = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_done_expiry();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/arb4_encode_ctrl.md
ARB4_ENCODE_CTRL -- requirements
Module: arb4_encode_ctrl

Interface
REQ-001 Parameter HOLD_MAX, default 15: maximum GRANT-state cycles per grant; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  request lines; req[3] is index 0, req[2] index 1, req[1] index 2, req[0] index 3.
REQ-005 done  input  1  current owner releases the resource; sampled only in GRANT.
REQ-006 gnt  output  4  registered one-hot grant, same bit order as req; all-zero when no grant.
REQ-007 gnt_idx  output  2  registered encoded grant index per the REQ-004 mapping; 2'b00 when no grant.
REQ-008 gnt_valid  output  1  high exactly when gnt is non-zero.
REQ-009 timeout  output  1  one-cycle pulse on forced release by HOLD_MAX expiry.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE, GRANT.
REQ-011 The block SHALL hold a 2-bit last-granted index (last) and an 8-bit hold counter (hcnt).
REQ-012 In IDLE with req != 0, the next edge SHALL enter GRANT, set gnt to the winner's bit, set gnt_idx to its index, set gnt_valid=1, set hcnt=0 and set last to the winner's index.
REQ-013 Winner selection SHALL be round-robin: search indices last+1, last+2, last+3, last (mod 4); the first requesting index wins.
REQ-014 In IDLE with req == 0, outputs SHALL stay zero and last SHALL hold.
REQ-015 Grant latency SHALL be exactly one cycle from the edge sampling the request in IDLE.
REQ-016 In GRANT, release SHALL occur on the edge where done=1, or where the owner's req bit is 0.
REQ-017 In GRANT without release, hcnt SHALL increment each cycle; if hcnt == HOLD_MAX-1 at an edge, forced release SHALL occur on that edge.
REQ-018 On any release, the next state SHALL be IDLE with gnt=0, gnt_idx=0, gnt_valid=0.
REQ-019 On a forced release, timeout SHALL be 1 for that following cycle only; timeout SHALL be 0 on done or req-drop releases.
REQ-020 When done and expiry coincide, done SHALL take precedence and timeout SHALL stay 0.
REQ-021 Every release SHALL be followed by at least one IDLE cycle, so back-to-back grants are spaced by one idle cycle.
REQ-022 Changes to non-owner req bits during GRANT SHALL NOT affect gnt.
REQ-023 gnt SHALL never have more than one bit set.
REQ-024 gnt_idx SHALL always equal the index encoding of gnt when gnt_valid=1.

Reset
REQ-025 While rst=1, the block SHALL force IDLE, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, hcnt=0 and last=3, so index 0 (req[3]) has first priority.
REQ-026 Assertion of rst mid-GRANT SHALL drop all outputs immediately, without waiting for a clock edge.
REQ-027 After rst deasserts, arbitration SHALL resume from the REQ-025 values on the first rising edge.

Verification
REQ-028 Reset, then req=4'b1111 held with done pulsed each grant -> grant order gnt_idx 0,1,2,3,0, each grant separated by one IDLE cycle.
REQ-029 Reset, then req=4'b0001 -> one edge later gnt=4'b0001, gnt_idx=2'b11, gnt_valid=1; drop req[0] -> next edge all outputs 0, timeout=0.
REQ-030 HOLD_MAX=4, req=4'b0100 held, done=0 -> gnt valid for 4 cycles, then IDLE with timeout=1 for one cycle, then a re-grant to index 1.
REQ-031 Grant held on index 1 with done=1 on the same edge hcnt reaches HOLD_MAX-1 -> release to IDLE, timeout=0.
REQ-032 rst asserted between edges during GRANT -> gnt, gnt_idx and gnt_valid go to 0 before the next edge; after rst release with req=4'b1111 -> first grant is index 0.
REQ-033 Random req/done stimulus over 10k cycles -> gnt always one-hot or zero, gnt_idx consistent with gnt, no requester starved beyond 4 consecutive grants to others.
